// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: state encodings, latched decoder
// flags and parameter defaults used by both the RTL and the bench.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic load;
    logic store;
    logic halt;
    logic wren;
  } dec_flags_t;

  localparam int CNT_W_DEF       = 32;
  localparam int ACK_TIMEOUT_DEF = 16;

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction/data memory handshake between the sequencer (master) and the
// memory side (slave).
interface core_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer with bounded memory-acknowledge waits.
//
// state  | meaning
// FETCH  | request instruction, wait for imem_ack
// DECODE | latch decoder flags, pick halt or execute
// EXEC   | route memory ops to MEM, others to WB
// MEM    | request data access, wait for dmem_ack
// WB     | register/PC writeback, retire instruction
// HALT   | stopped (err=1 if by timeout or bad state), left only by rst
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  core_sequencer_if.master      mem,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_halt,
  input  logic                  wren,
  input  logic                  br_taken,
  output logic                  ir_we,
  output logic                  rf_we,
  output logic                  pc_we,
  output logic                  pc_sel_br,
  output logic [2:0]            state,
  output logic                  halted,
  output logic                  err,
  output logic [CNT_W-1:0]      retired_cnt
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  dec_flags_t        flags_q, flags_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic              rf_we_q, rf_we_d;
  logic              pc_we_q, pc_we_d;
  logic              halted_q, halted_d;

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      ST_FETCH: begin
        // an ack in the last allowed cycle still wins over the timeout
        if (mem.imem_ack) begin
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        flags_d = '{load: is_load, store: is_store, halt: is_halt, wren: wren};
        state_d = is_halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        if (flags_q.halt) begin
          state_d = ST_HALT;
        end else if (flags_q.load || flags_q.store) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem.dmem_ack) begin
          state_d = ST_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WB: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = ST_FETCH;
        wait_d  = '0;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end
    endcase

    // Moore outputs are registered, so they are decoded from the next state
    imem_req_d = (state_d == ST_FETCH);
    dmem_req_d = (state_d == ST_MEM);
    dmem_we_d  = (state_d == ST_MEM) && flags_d.store;
    rf_we_d    = (state_d == ST_WB) && flags_d.wren && !flags_d.store;
    pc_we_d    = (state_d == ST_WB);
    halted_d   = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      flags_q    <= '0;
      wait_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      pc_we_q    <= pc_we_d;
      halted_q   <= halted_d;
    end
  end

  assign mem.imem_req = imem_req_q;
  assign mem.dmem_req = dmem_req_q;
  assign mem.dmem_we  = dmem_we_q;
  assign ir_we        = imem_req_q & mem.imem_ack;
  assign rf_we        = rf_we_q;
  assign pc_we        = pc_we_q;
  // branch select is only meaningful alongside the WB-only pc_we strobe
  assign pc_sel_br    = pc_we_q & br_taken;
  assign state        = state_q;
  assign halted       = halted_q;
  assign err          = err_q;
  assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: ALU/load/store flows, halt, ack timeout
// boundary and reset during a data access.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        is_load = 1'b0, is_store = 1'b0, is_halt = 1'b0, wren = 1'b0;
  logic        br_taken = 1'b0;
  logic        ir_we, rf_we, pc_we, pc_sel_br, halted, err;
  logic [2:0]  state;
  logic [31:0] retired_cnt;
  int          n_total = 0;
  int          n_bad = 0;

  core_sequencer_if mem_if ();

  core_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mem_if),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_halt     (is_halt),
    .wren        (wren),
    .br_taken    (br_taken),
    .ir_we       (ir_we),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .pc_sel_br   (pc_sel_br),
    .state       (state),
    .halted      (halted),
    .err         (err),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0; wren = 1'b0; br_taken = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'(ST_FETCH));
    check("rst_cnt", retired_cnt, 0);
    check("rst_err", 32'(err), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_dmem_req", 32'(mem_if.dmem_req), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // waits n cycles in FETCH without ack, then acks; returns in DECODE
  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) begin
      check("fetch_state", 32'(state), 32'(ST_FETCH));
      check("fetch_req", 32'(mem_if.imem_req), 1);
      check("fetch_ir_we_idle", 32'(ir_we), 0);
      step();
    end
    check("fetch_state", 32'(state), 32'(ST_FETCH));
    mem_if.imem_ack = 1'b1;
    #1;
    check("fetch_ir_we", 32'(ir_we), 1);
    step();
    mem_if.imem_ack = 1'b0;
  endtask

  // presents decoder flags for one cycle, then inverts them to prove they are ignored
  task automatic decode(input logic ld, input logic st, input logic hlt, input logic wr);
    check("dec_state", 32'(state), 32'(ST_DECODE));
    check("dec_imem_req", 32'(mem_if.imem_req), 0);
    is_load = ld; is_store = st; is_halt = hlt; wren = wr;
    step();
    is_load = ~ld; is_store = ~st; is_halt = ~hlt; wren = ~wr;
  endtask

  initial begin
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    #2;
    do_reset();
    check("first_imem_req", 32'(mem_if.imem_req), 1);

    // ALU op with wren, ack one cycle after request
    fetch(1);
    decode(1'b0, 1'b0, 1'b0, 1'b1);
    check("alu_exec_state", 32'(state), 32'(ST_EXEC));
    check("alu_exec_pc_we", 32'(pc_we), 0);
    step();
    check("alu_wb_state", 32'(state), 32'(ST_WB));
    check("alu_wb_rf_we", 32'(rf_we), 1);
    check("alu_wb_pc_we", 32'(pc_we), 1);
    check("alu_wb_sel_br", 32'(pc_sel_br), 0);
    step();
    check("alu_retired", retired_cnt, 1);

    // load, dmem_ack in the 4th MEM cycle; stray dmem_ack during FETCH
    mem_if.dmem_ack = 1'b1;
    check("fetch_stray_dack", 32'(state), 32'(ST_FETCH));
    step();
    mem_if.dmem_ack = 1'b0;
    fetch(0);
    decode(1'b1, 1'b0, 1'b0, 1'b1);
    check("ld_exec_dmem_req", 32'(mem_if.dmem_req), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("ld_mem_state", 32'(state), 32'(ST_MEM));
      check("ld_mem_req", 32'(mem_if.dmem_req), 1);
      check("ld_mem_we", 32'(mem_if.dmem_we), 0);
      if (i == 3) mem_if.dmem_ack = 1'b1;
      step();
    end
    mem_if.dmem_ack = 1'b0;
    check("ld_wb_state", 32'(state), 32'(ST_WB));
    check("ld_wb_dmem_req", 32'(mem_if.dmem_req), 0);
    check("ld_wb_rf_we", 32'(rf_we), 1);
    step();
    check("ld_retired", retired_cnt, 2);

    // store with wren and taken branch; br_taken outside WB has no effect
    fetch(2);
    decode(1'b0, 1'b1, 1'b0, 1'b1);
    br_taken = 1'b1;
    check("st_exec_sel_br", 32'(pc_sel_br), 0);
    step();
    check("st_mem_state", 32'(state), 32'(ST_MEM));
    check("st_mem_we", 32'(mem_if.dmem_we), 1);
    mem_if.imem_ack = 1'b1;
    #1;
    check("st_mem_ir_we", 32'(ir_we), 0);
    mem_if.dmem_ack = 1'b1;
    step();
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    check("st_wb_state", 32'(state), 32'(ST_WB));
    check("st_wb_rf_we", 32'(rf_we), 0);
    check("st_wb_pc_we", 32'(pc_we), 1);
    check("st_wb_sel_br", 32'(pc_sel_br), 1);
    step();
    br_taken = 1'b0;
    check("st_retired", retired_cnt, 3);

    // ack arriving on the last allowed wait cycle wins
    fetch(ACK_TIMEOUT_DEF - 1);
    check("edge_ack_state", 32'(state), 32'(ST_DECODE));
    check("edge_ack_err", 32'(err), 0);

    // halt in DECODE, then acks are ignored
    decode(1'b0, 1'b0, 1'b1, 1'b0);
    check("halt_state", 32'(state), 32'(ST_HALT));
    check("halt_halted", 32'(halted), 1);
    check("halt_err", 32'(err), 0);
    mem_if.imem_ack = 1'b1;
    mem_if.dmem_ack = 1'b1;
    step();
    step();
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    check("halt_hold_state", 32'(state), 32'(ST_HALT));
    check("halt_imem_req", 32'(mem_if.imem_req), 0);
    check("halt_pc_we", 32'(pc_we), 0);
    check("halt_retired", retired_cnt, 3);

    // fetch timeout: no ack for the full window
    do_reset();
    for (int i = 0; i < ACK_TIMEOUT_DEF; i++) begin
      check("to_wait_state", 32'(state), 32'(ST_FETCH));
      step();
    end
    check("to_state", 32'(state), 32'(ST_HALT));
    check("to_err", 32'(err), 1);
    check("to_halted", 32'(halted), 1);
    check("to_imem_req", 32'(mem_if.imem_req), 0);

    // reset while a data access is pending
    do_reset();
    fetch(0);
    decode(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("pre_wb_rf_we", 32'(rf_we), 0);
    step();
    check("pre_retired", retired_cnt, 1);
    fetch(0);
    decode(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check("mr_mem_req", 32'(mem_if.dmem_req), 1);
    step();
    do_reset();
    check("mr_after_imem_req", 32'(mem_if.imem_req), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
